// File: rtl/obf_key_mux_bank_pkg.sv
// rtl/obf_key_mux_bank_pkg.sv - shared types and helpers for the obfuscation key-mux bank
package obf_pkg;

    typedef enum logic [1:0] {
        PASS = 2'b00,
        INV  = 2'b01,
        ONE  = 2'b10,
        ZERO = 2'b11
    } obf_sel_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        LOAD   = 2'b01,
        COMMIT = 2'b10
    } obf_state_e;

    function automatic int key_bits(input int n);
        return 2 * n;
    endfunction

endpackage

// File: rtl/obf_key_mux_bank_if.sv
// rtl/obf_key_mux_bank_if.sv - serial key port and obfuscated net bundle
interface obf_key_mux_bank_if #(
    parameter int NUM_GATES = 4
);
    logic                 key_bit;
    logic                 key_valid;
    logic                 key_ready;
    logic                 key_abort;
    logic [NUM_GATES-1:0] net_in;
    logic [NUM_GATES-1:0] net_out;
    logic                 keyed;
    logic                 key_lock;

    modport master (
        output key_bit, key_valid, key_abort, net_in,
        input  key_ready, net_out, keyed, key_lock
    );

    modport slave (
        input  key_bit, key_valid, key_abort, net_in,
        output key_ready, net_out, keyed, key_lock
    );
endinterface

// File: rtl/obf_key_mux_bank_cell.sv
// rtl/obf_key_mux_bank_cell.sv - one camouflaged gate: 4:1 select of net, ~net, 1, 0
module obf_cell
    import obf_pkg::*;
(
    input  logic     net,
    input  obf_sel_e sel,
    output logic     out
);
    always_comb begin
        out = net;
        case (sel)
            PASS:    out = net;
            INV:     out = ~net;
            ONE:     out = 1'b1;
            ZERO:    out = 1'b0;
            default: out = net;
        endcase
    end
endmodule

// File: rtl/obf_key_mux_bank.sv
// rtl/obf_key_mux_bank.sv - key-controlled gate bank with serial shadow load and atomic commit
module obf_key_mux_bank
    import obf_pkg::*;
#(
    parameter int NUM_GATES = 4,
    parameter int OUT_REG   = 0,
    parameter int RELOAD_EN = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    obf_key_mux_bank_if.slave bus
);
    localparam int KEY_BITS = key_bits(NUM_GATES);
    localparam int CNT_W    = $clog2(KEY_BITS) + 1;

    obf_state_e          state, state_next;
    logic [CNT_W-1:0]    cnt, cnt_next;
    logic [KEY_BITS-1:0] shadow, shadow_next;
    logic [KEY_BITS-1:0] active_key;
    logic                keyed_q;
    logic                lock_q;
    logic                ready;
    logic                xfer;
    logic [NUM_GATES-1:0] cell_out;

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        shadow_next = shadow;
        ready       = 1'b0;
        case (state)
            IDLE:    ready = !lock_q;
            LOAD:    ready = 1'b1;
            COMMIT:  ready = 1'b0;
            default: ready = 1'b0;
        endcase
        xfer = bus.key_valid && ready;

        // Abort outranks a coinciding transfer, including the final one.
        if (state == COMMIT) begin
            state_next = IDLE;
            cnt_next   = '0;
        end else if (bus.key_abort) begin
            state_next  = IDLE;
            cnt_next    = '0;
            shadow_next = '0;
        end else if (xfer) begin
            for (int b = 0; b < KEY_BITS; b++) begin
                if (cnt == CNT_W'(b)) begin
                    shadow_next[b] = bus.key_bit;
                end
            end
            if (cnt == CNT_W'(KEY_BITS - 1)) begin
                state_next = COMMIT;
                cnt_next   = '0;
            end else begin
                state_next = LOAD;
                cnt_next   = cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            shadow     <= '0;
            active_key <= '1;
            keyed_q    <= 1'b0;
            lock_q     <= 1'b0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            shadow <= shadow_next;
            if (state == COMMIT) begin
                active_key <= shadow;
                keyed_q    <= 1'b1;
                lock_q     <= (RELOAD_EN == 0);
            end
        end
    end

    for (genvar i = 0; i < NUM_GATES; i++) begin : g_cell
        obf_cell u_cell (
            .net (bus.net_in[i]),
            .sel (obf_sel_e'(active_key[2*i+1 -: 2])),
            .out (cell_out[i])
        );
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [NUM_GATES-1:0] net_q;
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                net_q <= '0;
            end else begin
                net_q <= cell_out;
            end
        end
        assign bus.net_out = net_q;
    end else begin : g_out_comb
        assign bus.net_out = cell_out;
    end

    assign bus.key_ready = ready;
    assign bus.keyed     = keyed_q;
    assign bus.key_lock  = lock_q;
endmodule

// File: tb/tb_obf_key_mux_bank.sv
// tb/tb_obf_key_mux_bank.sv - directed bench over lock, reload and registered-output variants
module tb_obf_key_mux_bank;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_bit;
    logic       key_valid;
    logic       key_abort;
    logic [3:0] net_in;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    obf_key_mux_bank_if #(.NUM_GATES(4)) if0 ();
    obf_key_mux_bank_if #(.NUM_GATES(4)) if1 ();
    obf_key_mux_bank_if #(.NUM_GATES(4)) if2 ();

    assign if0.key_bit = key_bit;  assign if0.key_valid = key_valid;
    assign if0.key_abort = key_abort; assign if0.net_in = net_in;
    assign if1.key_bit = key_bit;  assign if1.key_valid = key_valid;
    assign if1.key_abort = key_abort; assign if1.net_in = net_in;
    assign if2.key_bit = key_bit;  assign if2.key_valid = key_valid;
    assign if2.key_abort = key_abort; assign if2.net_in = net_in;

    // d0: combinational, locks after commit; d1: combinational, reloadable; d2: registered, reloadable
    obf_key_mux_bank #(.NUM_GATES(4), .OUT_REG(0), .RELOAD_EN(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0.slave));
    obf_key_mux_bank #(.NUM_GATES(4), .OUT_REG(0), .RELOAD_EN(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1.slave));
    obf_key_mux_bank #(.NUM_GATES(4), .OUT_REG(1), .RELOAD_EN(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(if2.slave));

    typedef struct {
        logic [3:0] net_in;
        logic [3:0] exp;
    } vec_t;

    vec_t       vecs [6];
    logic [7:0] sweep_keys [5];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic chk(input string tag, input int d, input logic [3:0] out_e,
                       input logic keyed_e, input logic ready_e, input logic lock_e);
        logic [3:0] o;
        logic       k, r, l;
        case (d)
            0:       begin o = if0.net_out; k = if0.keyed; r = if0.key_ready; l = if0.key_lock; end
            1:       begin o = if1.net_out; k = if1.keyed; r = if1.key_ready; l = if1.key_lock; end
            default: begin o = if2.net_out; k = if2.keyed; r = if2.key_ready; l = if2.key_lock; end
        endcase
        check($sformatf("%s d%0d net_out", tag, d), 32'(o), 32'(out_e));
        check($sformatf("%s d%0d keyed", tag, d), 32'(k), 32'(keyed_e));
        check($sformatf("%s d%0d key_ready", tag, d), 32'(r), 32'(ready_e));
        check($sformatf("%s d%0d key_lock", tag, d), 32'(l), 32'(lock_e));
    endtask

    task automatic send_bits(input logic [7:0] key, input int lo, input int hi, input int abort_at);
        for (int i = lo; i <= hi; i++) begin
            key_valid = 1'b1;
            key_bit   = key[i];
            key_abort = (i == abort_at);
            tick();
        end
        key_valid = 1'b0;
        key_bit   = 1'b0;
        key_abort = 1'b0;
    endtask

    // Reference for the select table: 00 net, 01 ~net, 10 one, 11 zero per gate.
    function automatic logic [3:0] model(input logic [7:0] key, input logic [3:0] v);
        logic [3:0] r;
        logic [1:0] s;
        r = '0;
        for (int g = 0; g < 4; g++) begin
            s = key[2*g+1 -: 2];
            case (s)
                2'b00:   r[g] = v[g];
                2'b01:   r[g] = ~v[g];
                2'b10:   r[g] = 1'b1;
                default: r[g] = 1'b0;
            endcase
        end
        return r;
    endfunction

    initial begin
        logic [3:0] prev;
        logic [3:0] v;

        vecs[0] = '{4'b1010, 4'b1110};
        vecs[1] = '{4'b0000, 4'b0110};
        vecs[2] = '{4'b0101, 4'b0010};
        vecs[3] = '{4'b1111, 4'b1010};
        vecs[4] = '{4'b0100, 4'b0010};
        vecs[5] = '{4'b1000, 4'b1110};
        sweep_keys = '{8'h00, 8'h55, 8'hAA, 8'hFF, 8'h1B};

        rst_n = 1'b0; key_bit = 1'b0; key_valid = 1'b0; key_abort = 1'b0; net_in = 4'b1010;
        tick(); tick();
        rst_n = 1'b1;
        for (int d = 0; d < 3; d++) chk("reset", d, 4'b0000, 1'b0, 1'b1, 1'b0);

        // Key 0x1B: gate0 ZERO, gate1 ONE, gate2 INV, gate3 PASS; COMMIT follows the 8th bit
        send_bits(8'h1B, 0, 7, -1);
        for (int d = 0; d < 3; d++) chk("commit_cycle", d, 4'b0000, 1'b0, 1'b0, 1'b0);
        tick();
        chk("post_commit", 0, 4'b1110, 1'b1, 1'b0, 1'b1);
        chk("post_commit", 1, 4'b1110, 1'b1, 1'b1, 1'b0);
        chk("post_commit", 2, 4'b0000, 1'b1, 1'b1, 1'b0);
        tick();
        check("out_reg_visible d2", 32'(if2.net_out), 32'(4'b1110));

        for (int i = 0; i < 6; i++) begin
            net_in = vecs[i].net_in;
            #1;
            check($sformatf("vec%0d d0", i), 32'(if0.net_out), 32'(vecs[i].exp));
            tick();
            check($sformatf("vec%0d d2", i), 32'(if2.net_out), 32'(vecs[i].exp));
        end

        // Locked bank drops a further key; reloadable banks take all-PASS
        net_in = 4'b1010;
        send_bits(8'h00, 0, 7, -1);
        tick(); tick();
        chk("locked", 0, 4'b1110, 1'b1, 1'b0, 1'b1);
        chk("reload", 1, 4'b1010, 1'b1, 1'b1, 1'b0);
        chk("reload", 2, 4'b1010, 1'b1, 1'b1, 1'b0);

        for (int k = 0; k < 5; k++) begin
            send_bits(sweep_keys[k], 0, 7, -1);
            tick(); tick();
            prev = net_in;
            for (int n = 0; n < 16; n++) begin
                v = 4'(n);
                net_in = v;
                #1;
                check($sformatf("sweep k%0h v%0h d1", sweep_keys[k], v),
                      32'(if1.net_out), 32'(model(sweep_keys[k], v)));
                check($sformatf("sweep k%0h v%0h d2 hold", sweep_keys[k], v),
                      32'(if2.net_out), 32'(model(sweep_keys[k], prev)));
                tick();
                check($sformatf("sweep k%0h v%0h d2", sweep_keys[k], v),
                      32'(if2.net_out), 32'(model(sweep_keys[k], v)));
                prev = v;
            end
        end

        // Abort coinciding with the final bit: no commit, and the next load starts clean
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        net_in = 4'b1010;
        for (int d = 0; d < 3; d++) chk("reset2", d, 4'b0000, 1'b0, 1'b1, 1'b0);
        send_bits(8'h1B, 0, 7, 7);
        tick();
        for (int d = 0; d < 3; d++) chk("abort", d, 4'b0000, 1'b0, 1'b1, 1'b0);
        send_bits(8'h1B, 0, 6, -1);
        chk("after_abort_7bits", 0, 4'b0000, 1'b0, 1'b1, 1'b0);
        send_bits(8'h1B, 7, 7, -1);
        chk("after_abort_commit", 0, 4'b0000, 1'b0, 1'b0, 1'b0);
        tick();
        chk("after_abort_keyed", 0, 4'b1110, 1'b1, 1'b0, 1'b1);
        chk("after_abort_keyed", 1, 4'b1110, 1'b1, 1'b1, 1'b0);

        // Reset in the middle of a reload discards the partial key
        send_bits(8'h00, 0, 4, -1);
        rst_n = 1'b0;
        tick();
        chk("reset_mid_load", 1, 4'b0000, 1'b0, 1'b1, 1'b0);
        chk("reset_mid_load", 2, 4'b0000, 1'b0, 1'b1, 1'b0);
        rst_n = 1'b1;
        send_bits(8'h1B, 0, 6, -1);
        check("fresh_load_no_early_commit d1", 32'(if1.key_ready), 32'(1'b1));
        send_bits(8'h1B, 7, 7, -1);
        tick();
        chk("fresh_load", 1, 4'b1110, 1'b1, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
